// File: rtl/controle_ajuste.sv
// Time-setting controller for an HH:MM clock: mode button walks
// RUN -> SET_H -> SET_M -> COMMIT, inc button edits the selected field.
module controle_ajuste (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] cur_h_dez,
  input  logic [3:0] cur_h_unid,
  input  logic [2:0] cur_m_dez,
  input  logic [3:0] cur_m_unid,
  output logic       run_en,
  output logic       ld,
  output logic [1:0] ld_h_dez,
  output logic [3:0] ld_h_unid,
  output logic [2:0] ld_m_dez,
  output logic [3:0] ld_m_unid,
  output logic [1:0] disp_h_dez,
  output logic [3:0] disp_h_unid,
  output logic [2:0] disp_m_dez,
  output logic [3:0] disp_m_unid,
  output logic       blank_h,
  output logic       blank_m,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetH   = 2'd1,
    StSetM   = 2'd2,
    StCommit = 2'd3
  } state_e;

  localparam logic [3:0] TimeoutLimit = 4'd10;

  state_e     state_q;
  logic       mode_prev_q, inc_prev_q;
  logic [1:0] h_dez_q;
  logic [3:0] h_unid_q;
  logic [2:0] m_dez_q;
  logic [3:0] m_unid_q;
  logic [3:0] timeout_q;
  logic       phase_q;

  logic       mode_press, inc_press;
  logic [1:0] h_dez_inc;
  logic [3:0] h_unid_inc;
  logic [2:0] m_dez_inc;
  logic [3:0] m_unid_inc;

  assign mode_press = btn_mode & ~mode_prev_q;
  assign inc_press  = btn_inc & ~inc_prev_q;

  // BCD increment of the edit fields: hour wraps 23 -> 00, minute wraps 59 -> 00
  always_comb begin
    h_dez_inc  = h_dez_q;
    h_unid_inc = h_unid_q + 4'd1;
    if (h_dez_q == 2'd2 && h_unid_q == 4'd3) begin
      h_dez_inc  = 2'd0;
      h_unid_inc = 4'd0;
    end else if (h_unid_q == 4'd9) begin
      h_dez_inc  = h_dez_q + 2'd1;
      h_unid_inc = 4'd0;
    end
    m_dez_inc  = m_dez_q;
    m_unid_inc = m_unid_q + 4'd1;
    if (m_unid_q == 4'd9) begin
      m_unid_inc = 4'd0;
      m_dez_inc  = (m_dez_q == 3'd5) ? 3'd0 : m_dez_q + 3'd1;
    end
  end

  // FSM, edit registers, timeout and blink phase; presses take priority over timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      h_dez_q     <= 2'd0;
      h_unid_q    <= 4'd0;
      m_dez_q     <= 3'd0;
      m_unid_q    <= 4'd0;
      timeout_q   <= 4'd0;
      phase_q     <= 1'b0;
    end else begin
      mode_prev_q <= btn_mode;
      inc_prev_q  <= btn_inc;
      unique case (state_q)
        StRun: begin
          if (mode_press) begin
            state_q   <= StSetH;
            h_dez_q   <= cur_h_dez;
            h_unid_q  <= cur_h_unid;
            m_dez_q   <= cur_m_dez;
            m_unid_q  <= cur_m_unid;
            timeout_q <= 4'd0;
            phase_q   <= 1'b0;
          end
        end
        StSetH, StSetM: begin
          if (mode_press) begin
            // Simultaneous inc press is discarded here
            state_q   <= (state_q == StSetH) ? StSetM : StCommit;
            timeout_q <= 4'd0;
            phase_q   <= 1'b0;
          end else if (inc_press) begin
            timeout_q <= 4'd0;
            if (tick_1hz) phase_q <= ~phase_q;
            if (state_q == StSetH) begin
              h_dez_q  <= h_dez_inc;
              h_unid_q <= h_unid_inc;
            end else begin
              m_dez_q  <= m_dez_inc;
              m_unid_q <= m_unid_inc;
            end
          end else if (timeout_q == TimeoutLimit) begin
            state_q <= StRun;
          end else if (tick_1hz) begin
            timeout_q <= timeout_q + 4'd1;
            phase_q   <= ~phase_q;
          end
        end
        StCommit: state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    estado    = state_q;
    run_en    = (state_q == StRun);
    ld        = (state_q == StCommit);
    ld_h_dez  = h_dez_q;
    ld_h_unid = h_unid_q;
    ld_m_dez  = m_dez_q;
    ld_m_unid = m_unid_q;
    blank_h   = phase_q & (state_q == StSetH);
    blank_m   = phase_q & (state_q == StSetM);
    if (state_q == StRun) begin
      disp_h_dez  = cur_h_dez;
      disp_h_unid = cur_h_unid;
      disp_m_dez  = cur_m_dez;
      disp_m_unid = cur_m_unid;
    end else begin
      disp_h_dez  = h_dez_q;
      disp_h_unid = h_unid_q;
      disp_m_dez  = m_dez_q;
      disp_m_unid = m_unid_q;
    end
  end

endmodule

// File: tb/tb_controle_ajuste.sv
// Directed bench for controle_ajuste.
module tb_controle_ajuste;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, btn_mode, btn_inc;
  logic [1:0] cur_h_dez;
  logic [3:0] cur_h_unid;
  logic [2:0] cur_m_dez;
  logic [3:0] cur_m_unid;
  logic       run_en, ld, blank_h, blank_m;
  logic [1:0] ld_h_dez, disp_h_dez, estado;
  logic [3:0] ld_h_unid, ld_m_unid, disp_h_unid, disp_m_unid;
  logic [2:0] ld_m_dez, disp_m_dez;

  int checks = 0;
  int failures = 0;
  int ld_seen;

  controle_ajuste dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h_dez(cur_h_dez), .cur_h_unid(cur_h_unid), .cur_m_dez(cur_m_dez),
    .cur_m_unid(cur_m_unid), .run_en(run_en), .ld(ld), .ld_h_dez(ld_h_dez),
    .ld_h_unid(ld_h_unid), .ld_m_dez(ld_m_dez), .ld_m_unid(ld_m_unid),
    .disp_h_dez(disp_h_dez), .disp_h_unid(disp_h_unid), .disp_m_dez(disp_m_dez),
    .disp_m_unid(disp_m_unid), .blank_h(blank_h), .blank_m(blank_m), .estado(estado)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] hm(input int h, input int m);
    logic [1:0] hd;
    logic [3:0] hu;
    logic [2:0] md;
    logic [3:0] mu;
    hd = 2'(h / 10);
    hu = 4'(h % 10);
    md = 3'(m / 10);
    mu = 4'(m % 10);
    return {hd, hu, md, mu};
  endfunction

  wire [12:0] disp_v = {disp_h_dez, disp_h_unid, disp_m_dez, disp_m_unid};
  wire [12:0] ld_v   = {ld_h_dez, ld_h_unid, ld_m_dez, ld_m_unid};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cur(input int h, input int m);
    {cur_h_dez, cur_h_unid, cur_m_dez, cur_m_unid} = hm(h, m);
  endtask

  // Press lasts one cycle; caller must step once more before the next press
  task automatic press_mode();
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    step();
    btn_inc = 1'b0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    set_cur(12, 34);
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_estado", 16'(estado), 16'd0);
    chk("reset_run_en", 16'(run_en), 16'd1);
    chk("reset_ld", 16'(ld), 16'd0);
    chk("reset_ld_val", 16'(ld_v), 16'(hm(0, 0)));
    chk("reset_blank", 16'({blank_h, blank_m}), 16'd0);
    chk("reset_disp_cur", 16'(disp_v), 16'(hm(12, 34)));

    // Basic walk through all states
    press_mode();
    chk("walk_seth", 16'(estado), 16'd1);
    chk("walk_run_en0", 16'(run_en), 16'd0);
    step();
    press_mode();
    chk("walk_setm", 16'(estado), 16'd2);
    step();
    press_mode();
    chk("walk_commit", 16'(estado), 16'd3);
    chk("walk_ld1", 16'(ld), 16'd1);
    chk("walk_ld_val", 16'(ld_v), 16'(hm(12, 34)));
    step();
    chk("walk_back_run", 16'(estado), 16'd0);
    chk("walk_ld0", 16'(ld), 16'd0);
    chk("walk_run_en1", 16'(run_en), 16'd1);

    // BCD wrap of hours and minutes, blink on tick
    set_cur(22, 58);
    step();
    press_mode();
    chk("wrap_capture", 16'(disp_v), 16'(hm(22, 58)));
    step();
    press_inc();
    chk("wrap_h23", 16'(disp_v), 16'(hm(23, 58)));
    step();
    press_inc();
    chk("wrap_h00", 16'(disp_v), 16'(hm(0, 58)));
    step();
    press_mode();
    chk("wrap_setm", 16'(estado), 16'd2);
    tick();
    chk("blink_m", 16'({blank_h, blank_m}), 16'b01);
    press_inc();
    chk("wrap_m59", 16'(disp_v), 16'(hm(0, 59)));
    step();
    press_inc();
    chk("wrap_m00", 16'(disp_v), 16'(hm(0, 0)));
    step();
    press_mode();
    chk("wrap_commit_ld", 16'({ld, ld_v}), 16'({1'b1, hm(0, 0)}));
    step();

    // Timeout in SET_M discards edits and never loads
    set_cur(12, 34);
    step();
    press_mode();
    step();
    press_mode();
    chk("to_setm", 16'(estado), 16'd2);
    set_cur(7, 45);
    ld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ld) ld_seen++;
    end
    chk("to_still_setm", 16'(estado), 16'd2);
    chk("to_disp_edit", 16'(disp_v), 16'(hm(12, 34)));
    step();
    if (ld) ld_seen++;
    chk("to_run", 16'(estado), 16'd0);
    chk("to_no_ld", 16'(ld_seen), 16'd0);
    chk("to_disp_cur", 16'(disp_v), 16'(hm(7, 45)));

    // Simultaneous mode and inc: mode wins
    set_cur(12, 34);
    press_mode();
    step();
    btn_mode = 1'b1; btn_inc = 1'b1;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    chk("both_setm", 16'(estado), 16'd2);
    chk("both_hour_kept", 16'(disp_v), 16'(hm(12, 34)));
    step();
    press_mode();
    step();
    chk("both_run", 16'(estado), 16'd0);

    // Inc in RUN ignored
    press_inc();
    step();
    chk("inc_run_ignored", 16'({estado, ld_v}), 16'({2'd0, hm(12, 34)}));

    // Press coinciding with the timeout-reaching tick wins
    press_mode();
    for (int i = 0; i < 9; i++) tick();
    tick_1hz = 1'b1; btn_inc = 1'b1;
    step();
    tick_1hz = 1'b0; btn_inc = 1'b0;
    chk("race_inc", 16'(disp_v), 16'(hm(13, 34)));
    step(); step();
    chk("race_no_timeout", 16'(estado), 16'd1);

    // Reset during COMMIT aborts the load
    press_mode();
    step();
    press_mode();
    chk("rstc_commit", 16'(estado), 16'd3);
    rst = 1'b1;
    step();
    chk("rstc_ld0", 16'(ld), 16'd0);
    chk("rstc_state", 16'(estado), 16'd0);
    chk("rstc_edit", 16'(ld_v), 16'(hm(0, 0)));

    // Mode held across reset release produces no event
    btn_mode = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    chk("held_no_event", 16'(estado), 16'd0);
    btn_mode = 1'b0;
    step();
    press_mode();
    chk("held_release_press", 16'(estado), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
